// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit adder/subtractor. Each stage resolves one CW-bit slice
// and hands its carry, the resolved low sum bits and the still-unresolved
// upper operand bits to the next stage. The pipe stalls globally when the
// output holds a beat that downstream has not taken.
`timescale 1ns/1ps

module pipe_adder #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4   // WIDTH must be a multiple of STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int unsigned CW = WIDTH / STAGES;

    logic             advance;
    logic [WIDTH-1:0] b_eff;

    // Subtract is A + ~B + 1; the forced carry-in is applied at slice 0.
    assign b_eff = in_sub ? ~in_b : in_b;

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            localparam int unsigned LO    = k * CW;          // first bit resolved here
            localparam int unsigned RW_IN = WIDTH - LO;      // unresolved bits entering
            localparam int unsigned DONE  = LO + CW;         // resolved bits leaving
            localparam bit          LAST  = (k == STAGES - 1);
            // The last stage only keeps the operand MSBs, needed for overflow.
            localparam int unsigned AW    = LAST ? 1 : RW_IN - CW;

            logic [RW_IN-1:0] src_a;
            logic [RW_IN-1:0] src_bx;
            logic             src_c;
            logic             src_v;
            logic [CW:0]      slice;
            logic [DONE-1:0]  sum_d;
            logic [DONE-1:0]  sum_q;
            logic [AW-1:0]    a_d;
            logic [AW-1:0]    bx_d;
            logic [AW-1:0]    a_q;
            logic [AW-1:0]    bx_q;
            logic             valid_q;
            logic             carry_q;

            if (k == 0) begin : g_first
                assign src_a  = in_a;
                assign src_bx = b_eff;
                assign src_c  = in_sub | in_cin;
                assign src_v  = in_valid;
                assign sum_d  = slice[CW-1:0];
            end else begin : g_next
                assign src_a  = g_stage[k-1].a_q;
                assign src_bx = g_stage[k-1].bx_q;
                assign src_c  = g_stage[k-1].carry_q;
                assign src_v  = g_stage[k-1].valid_q;
                assign sum_d  = {slice[CW-1:0], g_stage[k-1].sum_q};
            end

            if (LAST) begin : g_msb
                assign a_d  = src_a[RW_IN-1];
                assign bx_d = src_bx[RW_IN-1];
            end else begin : g_rest
                assign a_d  = src_a[RW_IN-1:CW];
                assign bx_d = src_bx[RW_IN-1:CW];
            end

            assign slice = {1'b0, src_a[CW-1:0]} + {1'b0, src_bx[CW-1:0]}
                         + {{CW{1'b0}}, src_c};

            // Stage register: loads only on advance, so a stall freezes the whole pipe.
            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_q <= 1'b0;
                    carry_q <= 1'b0;
                    sum_q   <= '0;
                    a_q     <= '0;
                    bx_q    <= '0;
                end else if (advance) begin
                    valid_q <= src_v;
                    carry_q <= slice[CW];
                    sum_q   <= sum_d;
                    a_q     <= a_d;
                    bx_q    <= bx_d;
                end
            end
        end
    endgenerate

    assign out_valid = g_stage[STAGES-1].valid_q;
    assign out_sum   = g_stage[STAGES-1].sum_q;
    assign out_cout  = g_stage[STAGES-1].carry_q;
    // Signed overflow: operands agree in sign but the result does not.
    assign out_ovf   = (g_stage[STAGES-1].a_q[0] == g_stage[STAGES-1].bx_q[0])
                    && (g_stage[STAGES-1].sum_q[WIDTH-1] != g_stage[STAGES-1].a_q[0]);

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder: directed vector table on an 8-bit
// 4-stage instance, plus stall streaming, mid-flight reset, and 32-bit
// instances with 1 and 8 stages checked cycle-exactly against a model.
`timescale 1ns/1ps

module tb_pipe_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // 8-bit, 4-stage instance
    logic       d8_in_valid, d8_in_ready, d8_in_cin, d8_in_sub;
    logic       d8_out_valid, d8_out_ready, d8_out_cout, d8_out_ovf;
    logic [7:0] d8_in_a, d8_in_b, d8_out_sum;

    // 32-bit instances, shared inputs
    logic        w_in_valid, w_in_cin, w_in_sub, w_out_ready;
    logic [31:0] w_in_a, w_in_b;
    logic        w1_in_ready, w1_out_valid, w1_out_cout, w1_out_ovf;
    logic        w8_in_ready, w8_out_valid, w8_out_cout, w8_out_ovf;
    logic [31:0] w1_out_sum, w8_out_sum;

    pipe_adder #(.WIDTH(8), .STAGES(4)) u_dut8 (
        .clk(clk), .rst(rst),
        .in_valid(d8_in_valid), .in_ready(d8_in_ready),
        .in_a(d8_in_a), .in_b(d8_in_b), .in_cin(d8_in_cin), .in_sub(d8_in_sub),
        .out_valid(d8_out_valid), .out_ready(d8_out_ready),
        .out_sum(d8_out_sum), .out_cout(d8_out_cout), .out_ovf(d8_out_ovf)
    );

    pipe_adder #(.WIDTH(32), .STAGES(1)) u_dut32s1 (
        .clk(clk), .rst(rst),
        .in_valid(w_in_valid), .in_ready(w1_in_ready),
        .in_a(w_in_a), .in_b(w_in_b), .in_cin(w_in_cin), .in_sub(w_in_sub),
        .out_valid(w1_out_valid), .out_ready(w_out_ready),
        .out_sum(w1_out_sum), .out_cout(w1_out_cout), .out_ovf(w1_out_ovf)
    );

    pipe_adder #(.WIDTH(32), .STAGES(8)) u_dut32s8 (
        .clk(clk), .rst(rst),
        .in_valid(w_in_valid), .in_ready(w8_in_ready),
        .in_a(w_in_a), .in_b(w_in_b), .in_cin(w_in_cin), .in_sub(w_in_sub),
        .out_valid(w8_out_valid), .out_ready(w_out_ready),
        .out_sum(w8_out_sum), .out_cout(w8_out_cout), .out_ovf(w8_out_ovf)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    vec_t vecs[10];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Full-width reference: returns {ovf, cout, sum}
    function automatic logic [9:0] model8(input logic [7:0] a, input logic [7:0] b,
                                          input logic cin, input logic sub);
        logic [7:0] bx;
        logic [8:0] full;
        bx   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bx} + {8'b0, (sub | cin)};
        return {((a[7] == bx[7]) && (full[7] != a[7])), full[8], full[7:0]};
    endfunction

    function automatic logic [33:0] model32(input logic [31:0] a, input logic [31:0] b,
                                            input logic cin, input logic sub);
        logic [31:0] bx;
        logic [32:0] full;
        bx   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bx} + {32'b0, (sub | cin)};
        return {((a[31] == bx[31]) && (full[31] != a[31])), full[32], full[31:0]};
    endfunction

    // Entered and left 1 time unit after a rising edge.
    task automatic run_vec(input int idx);
        int lat;
        d8_in_a      = vecs[idx].a;
        d8_in_b      = vecs[idx].b;
        d8_in_cin    = vecs[idx].cin;
        d8_in_sub    = vecs[idx].sub;
        d8_in_valid  = 1'b1;
        d8_out_ready = 1'b1;
        #1;
        check($sformatf("vec%0d in_ready", idx), d8_in_ready, 1);
        @(posedge clk); #1;
        d8_in_valid = 1'b0;
        lat = 1;
        while (!d8_out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check($sformatf("vec%0d latency", idx), lat, 4);
        check($sformatf("vec%0d sum", idx), d8_out_sum, vecs[idx].sum);
        check($sformatf("vec%0d cout", idx), d8_out_cout, vecs[idx].cout);
        check($sformatf("vec%0d ovf", idx), d8_out_ovf, vecs[idx].ovf);
        @(posedge clk); #1;
        check($sformatf("vec%0d drained", idx), d8_out_valid, 0);
    endtask

    // Eight random beats back-to-back with out_ready cycling 1,0,0,1.
    task automatic stream_test();
        logic [7:0] sa[8];
        logic [7:0] sb[8];
        logic       scin[8];
        logic       ssub[8];
        logic [9:0] expq[$];
        logic [9:0] prev_out;
        logic       prev_hold;
        int sent, recv, cyc;
        for (int i = 0; i < 8; i++) begin
            sa[i]   = 8'($urandom);
            sb[i]   = 8'($urandom);
            scin[i] = 1'($urandom);
            ssub[i] = 1'($urandom);
        end
        sent = 0; recv = 0; cyc = 0; prev_hold = 1'b0; prev_out = '0;
        while (recv < 8 && cyc < 200) begin
            d8_out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            if (sent < 8) begin
                d8_in_a = sa[sent]; d8_in_b = sb[sent];
                d8_in_cin = scin[sent]; d8_in_sub = ssub[sent];
                d8_in_valid = 1'b1;
            end else begin
                d8_in_valid = 1'b0;
            end
            #1;
            if (prev_hold)
                check("stream stall hold", {d8_out_ovf, d8_out_cout, d8_out_sum}, prev_out);
            if (d8_out_valid && !d8_out_ready)
                check("stream in_ready during stall", d8_in_ready, 0);
            else
                check("stream in_ready when free", d8_in_ready, 1);
            if (d8_out_valid && d8_out_ready) begin
                if (expq.size() == 0) begin
                    check("stream unexpected result", 1, 0);
                end else begin
                    check($sformatf("stream result %0d", recv),
                          {d8_out_ovf, d8_out_cout, d8_out_sum}, expq.pop_front());
                    recv++;
                end
            end
            if (d8_in_valid && d8_in_ready) begin
                expq.push_back(model8(d8_in_a, d8_in_b, d8_in_cin, d8_in_sub));
                sent++;
            end
            prev_hold = d8_out_valid && !d8_out_ready;
            prev_out  = {d8_out_ovf, d8_out_cout, d8_out_sum};
            @(posedge clk); #1;
            cyc++;
        end
        check("stream received count", recv, 8);
        d8_in_valid  = 1'b0;
        d8_out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("stream no duplicate", d8_out_valid, 0);
        end
    endtask

    task automatic reset_midflight_test();
        d8_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d8_in_a = 8'h11 * 8'(i + 1); d8_in_b = 8'h22; d8_in_cin = 1'b0; d8_in_sub = 1'b0;
            d8_in_valid = 1'b1;
            @(posedge clk); #1;
        end
        d8_in_valid = 1'b0;
        check("full pipe out_valid", d8_out_valid, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midreset out_valid", d8_out_valid, 0);
        check("midreset out_sum", d8_out_sum, 0);
        check("midreset out_cout", d8_out_cout, 0);
        check("midreset out_ovf", d8_out_ovf, 0);
        check("midreset in_ready", d8_in_ready, 1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("post reset stays idle", d8_out_valid, 0);
        end
        run_vec(1);
    endtask

    // Both 32-bit pipes fed every cycle; results must appear exactly STAGES later.
    task automatic wide_test();
        localparam int N = 20;
        logic [33:0] exp[N];
        int i1, i8;
        w_out_ready = 1'b1;
        for (int j = 0; j < N + 9; j++) begin
            i1 = j - 1;
            i8 = j - 8;
            if (i1 >= 0 && i1 < N) begin
                check("w1 valid", w1_out_valid, 1);
                check($sformatf("w1 beat %0d", i1), {w1_out_ovf, w1_out_cout, w1_out_sum}, exp[i1]);
            end else begin
                check("w1 idle", w1_out_valid, 0);
            end
            if (i8 >= 0 && i8 < N) begin
                check("w8 valid", w8_out_valid, 1);
                check($sformatf("w8 beat %0d", i8), {w8_out_ovf, w8_out_cout, w8_out_sum}, exp[i8]);
            end else begin
                check("w8 idle", w8_out_valid, 0);
            end
            if (j < N) begin
                w_in_a   = (j == 0) ? 32'hFFFF_FFFF : $urandom;
                w_in_b   = (j == 0) ? 32'h0000_0001 : $urandom;
                w_in_cin = (j == 0) ? 1'b0 : 1'($urandom);
                w_in_sub = (j == 0) ? 1'b0 : 1'($urandom);
                w_in_valid = 1'b1;
                exp[j] = model32(w_in_a, w_in_b, w_in_cin, w_in_sub);
            end else begin
                w_in_valid = 1'b0;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        vecs[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[2] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[3] = '{8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[5] = '{8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0};
        vecs[6] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[7] = '{8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[8] = '{8'h7F, 8'hFF, 1'b1, 1'b1, 8'h80, 1'b0, 1'b1};
        vecs[9] = '{8'h55, 8'hAA, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0};

        rst = 1'b1;
        d8_in_valid = 1'b0; d8_in_a = '0; d8_in_b = '0; d8_in_cin = 1'b0; d8_in_sub = 1'b0;
        d8_out_ready = 1'b0;
        w_in_valid = 1'b0; w_in_a = '0; w_in_b = '0; w_in_cin = 1'b0; w_in_sub = 1'b0;
        w_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", d8_out_valid, 0);
        check("reset out_sum", d8_out_sum, 0);
        check("reset out_cout", d8_out_cout, 0);
        check("reset out_ovf", d8_out_ovf, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("in_ready after reset", d8_in_ready, 1);

        for (int i = 0; i < 10; i++) run_vec(i);
        stream_test();
        reset_midflight_test();
        wide_test();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
